// File: rtl/bankgroup_sched_pkg.sv
// Shared types and constants for the bank-group command sequencer.
package bankgroup_sched_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PRE,
    ACT,
    COL,
    PALL
  } state_e;

  typedef enum logic [1:0] {
    HIT,
    MISS,
    CONFLICT
  } class_e;

  localparam int STAT_W = 16;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/bankgroup_sched_if.sv
// Request / command bus between the channel request path and the sequencer.
interface bankgroup_sched_if #(
  parameter int BAWIDTH  = 2,
  parameter int CHWIDTH  = 5,
  parameter int COLWIDTH = 10
) ();
  import bankgroup_sched_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic [BAWIDTH-1:0]  req_bank;
  logic [CHWIDTH-1:0]  req_row;
  logic [COLWIDTH-1:0] req_col;
  logic                req_wr;
  logic                pall_req;
  logic                pall_done;
  logic                pre_valid;
  logic                act_valid;
  logic                cmd_valid;
  logic [BAWIDTH-1:0]  cmd_bank;
  logic [CHWIDTH-1:0]  cmd_row;
  logic [COLWIDTH-1:0] cmd_col;
  logic                cmd_wr;
  logic [STAT_W-1:0]   hit_cnt;
  logic [STAT_W-1:0]   miss_cnt;
  logic [STAT_W-1:0]   conflict_cnt;

  modport master (
    output req_valid, req_bank, req_row, req_col, req_wr, pall_req,
    input  req_ready, pall_done, pre_valid, act_valid, cmd_valid,
           cmd_bank, cmd_row, cmd_col, cmd_wr, hit_cnt, miss_cnt, conflict_cnt
  );

  modport slave (
    input  req_valid, req_bank, req_row, req_col, req_wr, pall_req,
    output req_ready, pall_done, pre_valid, act_valid, cmd_valid,
           cmd_bank, cmd_row, cmd_col, cmd_wr, hit_cnt, miss_cnt, conflict_cnt
  );

endinterface

// File: rtl/bank_open_table.sv
// Per-bank open flag and active row, with combinational lookup.
module bank_open_table #(
  parameter int BAWIDTH = 2,
  parameter int CHWIDTH = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [BAWIDTH-1:0] lookup_bank_i,
  output logic               lookup_open_o,
  output logic [CHWIDTH-1:0] lookup_row_o,
  input  logic               set_en_i,
  input  logic [BAWIDTH-1:0] set_bank_i,
  input  logic [CHWIDTH-1:0] set_row_i,
  input  logic               clr_en_i,
  input  logic [BAWIDTH-1:0] clr_bank_i,
  input  logic               clr_all_i
);
  localparam int NB = 2 ** BAWIDTH;

  logic [NB-1:0]      open_q;
  logic [CHWIDTH-1:0] row_q [NB];

  assign lookup_open_o = open_q[lookup_bank_i];
  assign lookup_row_o  = row_q[lookup_bank_i];

  // Table update: clear-all wins, otherwise clear-one then set-open.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      open_q <= '0;
      for (int i = 0; i < NB; i++) row_q[i] <= '0;
    end else if (clr_all_i) begin
      open_q <= '0;
    end else begin
      if (clr_en_i) open_q[clr_bank_i] <= 1'b0;
      if (set_en_i) begin
        open_q[set_bank_i] <= 1'b1;
        row_q[set_bank_i]  <= set_row_i;
      end
    end
  end

endmodule

// File: rtl/bankgroup_sched.sv
// Single-outstanding PRE/ACT/column sequencer for one bank group.
// Optional statistics counters: define BANKGROUP_SCHED_STATS_EN.
module bankgroup_sched
  import bankgroup_sched_pkg::*;
#(
  parameter int BAWIDTH  = 2,
  parameter int CHWIDTH  = 5,
  parameter int COLWIDTH = 10,
  parameter int TRP      = 3,
  parameter int TRCD     = 3,
  parameter int TCCD     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  bankgroup_sched_if.slave  bus
);
  localparam int WCW = $clog2(max2(TRP, TRCD) + 1);
  localparam int TCW = $clog2(TCCD + 1);
  localparam logic [WCW-1:0] TRP_LD  = WCW'(TRP - 1);
  localparam logic [WCW-1:0] TRCD_LD = WCW'(TRCD - 1);
  localparam logic [TCW-1:0] TCCD_LD = TCW'(TCCD - 1);

  state_e              state_q, state_d;
  logic [WCW-1:0]      wcnt_q, wcnt_d;
  logic [TCW-1:0]      tccd_q, tccd_d;
  logic [BAWIDTH-1:0]  bank_q, bank_d;
  logic [CHWIDTH-1:0]  row_q, row_d;
  logic [COLWIDTH-1:0] col_q, col_d;
  logic                wr_q, wr_d;
  logic                pall_done_q, pall_done_d;

  logic                lk_open;
  logic [CHWIDTH-1:0]  lk_row;
  logic                set_en, clr_en, clr_all;
  logic                pre_v, act_v, cmd_v, ready, accept;
  class_e              cls;

  bank_open_table #(.BAWIDTH(BAWIDTH), .CHWIDTH(CHWIDTH)) u_table (
    .clk           (clk),
    .rst_n         (rst_n),
    .lookup_bank_i (bus.req_bank),
    .lookup_open_o (lk_open),
    .lookup_row_o  (lk_row),
    .set_en_i      (set_en),
    .set_bank_i    (bank_q),
    .set_row_i     (row_q),
    .clr_en_i      (clr_en),
    .clr_bank_i    (bank_q),
    .clr_all_i     (clr_all)
  );

  assign ready = (state_q == IDLE) && !bus.pall_req;

  // Classify the presented request against the open-page table.
  always_comb begin
    cls = HIT;
    if (!lk_open)                    cls = MISS;
    else if (lk_row != bus.req_row)  cls = CONFLICT;
  end

  // Next-state, wait counters and command pulses.
  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    tccd_d      = (tccd_q != '0) ? tccd_q - 1'b1 : tccd_q;
    bank_d      = bank_q;
    row_d       = row_q;
    col_d       = col_q;
    wr_d        = wr_q;
    pall_done_d = 1'b0;
    set_en      = 1'b0;
    clr_en      = 1'b0;
    clr_all     = 1'b0;
    pre_v       = 1'b0;
    act_v       = 1'b0;
    cmd_v       = 1'b0;
    accept      = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.pall_req) begin
          state_d = PALL;
          wcnt_d  = TRP_LD;
        end else if (bus.req_valid) begin
          accept = 1'b1;
          bank_d = bus.req_bank;
          row_d  = bus.req_row;
          col_d  = bus.req_col;
          wr_d   = bus.req_wr;
          case (cls)
            MISS:     begin state_d = ACT; wcnt_d = TRCD_LD; end
            CONFLICT: begin state_d = PRE; wcnt_d = TRP_LD;  end
            default:  state_d = COL;
          endcase
        end
      end
      PRE: begin
        pre_v = (wcnt_q == TRP_LD);
        if (wcnt_q == '0) begin
          clr_en  = 1'b1;
          state_d = ACT;
          wcnt_d  = TRCD_LD;
        end else begin
          wcnt_d = wcnt_q - 1'b1;
        end
      end
      ACT: begin
        act_v  = (wcnt_q == TRCD_LD);
        set_en = act_v;
        if (wcnt_q == '0) state_d = COL;
        else              wcnt_d  = wcnt_q - 1'b1;
      end
      COL: begin
        if (tccd_q == '0) begin
          cmd_v   = 1'b1;
          tccd_d  = TCCD_LD;
          state_d = IDLE;
        end
      end
      PALL: begin
        pre_v = (wcnt_q == TRP_LD);
        if (wcnt_q == '0) begin
          clr_all     = 1'b1;
          pall_done_d = 1'b1;
          state_d     = IDLE;
        end else begin
          wcnt_d = wcnt_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State, counters and latched request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wcnt_q      <= '0;
      tccd_q      <= '0;
      bank_q      <= '0;
      row_q       <= '0;
      col_q       <= '0;
      wr_q        <= 1'b0;
      pall_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      tccd_q      <= tccd_d;
      bank_q      <= bank_d;
      row_q       <= row_d;
      col_q       <= col_d;
      wr_q        <= wr_d;
      pall_done_q <= pall_done_d;
    end
  end

  assign bus.req_ready = ready;
  assign bus.pre_valid = pre_v;
  assign bus.act_valid = act_v;
  assign bus.cmd_valid = cmd_v;
  assign bus.pall_done = pall_done_q;
  // Precharge-all is reported against bank 0 without disturbing the latched request.
  assign bus.cmd_bank  = (state_q == PALL) ? '0 : bank_q;
  assign bus.cmd_row   = row_q;
  assign bus.cmd_col   = col_q;
  assign bus.cmd_wr    = wr_q;

`ifdef BANKGROUP_SCHED_STATS_EN
  logic [STAT_W-1:0] hit_cnt_q, miss_cnt_q, conf_cnt_q;

  // Saturating per-class acceptance counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
      conf_cnt_q <= '0;
    end else if (accept) begin
      if (cls == HIT && hit_cnt_q != '1)       hit_cnt_q  <= hit_cnt_q + 1'b1;
      if (cls == MISS && miss_cnt_q != '1)     miss_cnt_q <= miss_cnt_q + 1'b1;
      if (cls == CONFLICT && conf_cnt_q != '1) conf_cnt_q <= conf_cnt_q + 1'b1;
    end
  end

  assign bus.hit_cnt      = hit_cnt_q;
  assign bus.miss_cnt     = miss_cnt_q;
  assign bus.conflict_cnt = conf_cnt_q;
`else
  assign bus.hit_cnt      = '0;
  assign bus.miss_cnt     = '0;
  assign bus.conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_bankgroup_sched.sv
// Bench for bankgroup_sched: directed scenarios plus randomized requests,
// checked cycle by cycle against a timing model of the open-page rules.
module tb_bankgroup_sched;
  localparam int BAW  = 2;
  localparam int CHW  = 5;
  localparam int COLW = 10;
  localparam int TRP  = 3;
  localparam int TRCD = 3;
  localparam int TCCD = 2;
  localparam int NB   = 2 ** BAW;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  bankgroup_sched_if #(.BAWIDTH(BAW), .CHWIDTH(CHW), .COLWIDTH(COLW)) bus ();

  bankgroup_sched #(
    .BAWIDTH(BAW), .CHWIDTH(CHW), .COLWIDTH(COLW),
    .TRP(TRP), .TRCD(TRCD), .TCCD(TCCD)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  // reference model state
  bit m_open [NB];
  int m_row  [NB];
  int last_cmd;
  int n_hit, n_miss, n_conf;

  task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NB; i++) begin
      m_open[i] = 1'b0;
      m_row[i]  = 0;
    end
    last_cmd = -100;
    n_hit = 0; n_miss = 0; n_conf = 0;
  endtask

  function automatic logic [31:0] pulses();
    return 32'({bus.pre_valid, bus.act_valid, bus.cmd_valid});
  endfunction

  task automatic check_stats();
`ifdef BANKGROUP_SCHED_STATS_EN
    chk_eq("hit_cnt",      32'(bus.hit_cnt),      n_hit);
    chk_eq("miss_cnt",     32'(bus.miss_cnt),     n_miss);
    chk_eq("conflict_cnt", 32'(bus.conflict_cnt), n_conf);
`else
    chk_eq("hit_cnt_off",      32'(bus.hit_cnt),      0);
    chk_eq("miss_cnt_off",     32'(bus.miss_cnt),     0);
    chk_eq("conflict_cnt_off", 32'(bus.conflict_cnt), 0);
`endif
  endtask

  task automatic check_all_zero(input string tag);
    chk_eq(tag, 32'({bus.pre_valid, bus.act_valid, bus.cmd_valid, bus.pall_done,
                     bus.cmd_wr, bus.cmd_bank, bus.cmd_row, bus.cmd_col}), 0);
  endtask

  // One request, from presentation to its column command.
  task automatic do_req(input int b, input int r, input int col, input int w);
    int T, pre_c, act_c, base, cmd_c, fexp;
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_bank  = BAW'(b);
    bus.req_row   = CHW'(r);
    bus.req_col   = COLW'(col);
    bus.req_wr    = w[0];
    #1;
    chk_eq("req_ready_idle", 32'(bus.req_ready), 1);
    T = cyc;
    pre_c = -1;
    act_c = -1;
    if (!m_open[b]) begin
      act_c = T + 1;
      base  = T + 1 + TRCD;
      n_miss++;
    end else if (m_row[b] != r) begin
      pre_c = T + 1;
      act_c = T + 1 + TRP;
      base  = T + 1 + TRP + TRCD;
      n_conf++;
    end else begin
      base = T + 1;
      n_hit++;
    end
    cmd_c = (base > last_cmd + TCCD) ? base : last_cmd + TCCD;
    m_open[b] = 1'b1;
    m_row[b]  = r;
    fexp = ((b & 3) << 16) | ((r & 31) << 11) | ((col & 1023) << 1) | (w & 1);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.req_bank  = BAW'($urandom);
    bus.req_row   = CHW'($urandom);
    bus.req_col   = COLW'($urandom);
    bus.req_wr    = 1'($urandom);
    for (int c = T + 1; c <= cmd_c; c++) begin
      if (c > T + 1) @(negedge clk);
      chk_eq("cmd_pulses", pulses(),
             32'({c == pre_c, c == act_c, c == cmd_c}));
      chk_eq("req_ready_busy", 32'(bus.req_ready), 0);
      chk_eq("cmd_fields", 32'({bus.cmd_bank, bus.cmd_row, bus.cmd_col, bus.cmd_wr}), fexp);
    end
    last_cmd = cmd_c;
    check_stats();
  endtask

  // Precharge-all raised together with a request; pall_req drops during PALL.
  task automatic do_pall();
    int E;
    @(negedge clk);
    bus.pall_req  = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_bank  = BAW'($urandom);
    bus.req_row   = CHW'($urandom);
    #1;
    chk_eq("req_ready_pall", 32'(bus.req_ready), 0);
    E = cyc + 1;
    @(negedge clk);
    chk_eq("pall_pre", pulses(), 32'b100);
    chk_eq("pall_bank", 32'(bus.cmd_bank), 0);
    bus.pall_req  = 1'b0;
    bus.req_valid = 1'b0;
    for (int c = E + 1; c <= E + TRP; c++) begin
      @(negedge clk);
      #1;
      chk_eq("pall_quiet", pulses(), 0);
      chk_eq("pall_done", 32'(bus.pall_done), 32'(c == E + TRP));
      chk_eq("pall_ready", 32'(bus.req_ready), 32'(c == E + TRP));
    end
    for (int i = 0; i < NB; i++) m_open[i] = 1'b0;
  endtask

  // Miss request aborted by reset while in ACT.
  task automatic reset_in_act(input int b, input int r);
    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.req_bank  = BAW'(b);
    bus.req_row   = CHW'(r);
    bus.req_col   = COLW'(11);
    bus.req_wr    = 1'b1;
    @(negedge clk);
    bus.req_valid = 1'b0;
    chk_eq("abort_act_pulse", pulses(), 32'b010);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all_zero("abort_outputs");
    chk_eq("abort_ready", 32'(bus.req_ready), 1);
    check_stats();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_bank  = '0;
    bus.req_row   = '0;
    bus.req_col   = '0;
    bus.req_wr    = 1'b0;
    bus.pall_req  = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    #1;
    check_all_zero("reset_outputs");
    chk_eq("reset_ready", 32'(bus.req_ready), 1);
    check_stats();
    bus.pall_req = 1'b1;
    #1;
    chk_eq("reset_ready_pall", 32'(bus.req_ready), 0);
    bus.pall_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    do_req(1, 5, 7, 0);   // miss
    do_req(1, 5, 8, 1);   // hit, back-to-back
    do_req(1, 9, 3, 0);   // conflict
    do_pall();
    do_req(1, 9, 4, 0);   // miss after precharge-all
    reset_in_act(2, 3);
    do_req(2, 3, 5, 0);   // miss after reset
    do_req(2, 3, 6, 1);   // hit
    do_req(2, 3, 7, 0);   // hit
    do_req(2, 3, 8, 1);   // hit
    do_req(3, 1, 1, 0);   // miss
    do_req(2, 7, 2, 1);   // conflict

    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(0, 11) == 0) do_pall();
      else do_req(int'($urandom_range(0, NB - 1)), int'($urandom_range(0, 2)),
                  int'($urandom_range(0, 1023)), int'($urandom_range(0, 1)));
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

endmodule
